// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multicycle RV32 control unit:
// FSM states, opcodes, ALU operations and datapath select codes.
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R,
    EXEC_I, ALU_WB, JAL, BEQ, FPU_EXEC, FPU_WB, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FLW    = 7'b0000111;
  localparam logic [6:0] OP_FSW    = 7'b0100111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FP     = 7'b1010011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_FPU    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational funct3/funct7 -> ALU operation; flags funct3 codes the ALU lacks.
// funct7 only selects sub for register-register ops, so addi never subtracts.
module alu_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7_i,
  input  logic       is_r_i,
  output logic [2:0] alu_control_o,
  output logic       bad_funct_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    bad_funct_o   = 1'b0;
    case (funct3_i)
      3'b000:  alu_control_o = (is_r_i && funct7_i) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control_o = ALU_SLT;
      3'b110:  alu_control_o = ALU_OR;
      3'b111:  alu_control_o = ALU_AND;
      default: bad_funct_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 control FSM with optional FPU wait/timeout path (macro RV32F_FPU_EN).
// Outputs are state-decoded; all write enables are forced low while rst_n is low.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned FPU_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       fpu_done,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic       float_reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       fpu_start,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [2:0] dec_alu;
  logic       dec_bad;

  alu_decoder u_alu_dec (
    .funct3_i      (funct3),
    .funct7_i      (funct7),
    .is_r_i        (state_q == EXEC_R),
    .alu_control_o (dec_alu),
    .bad_funct_o   (dec_bad)
  );

`ifdef RV32F_FPU_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FPU_TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts cycles spent in FPU_EXEC; zero on entry marks the launch cycle.
  assign cnt_d = (state_q == FPU_EXEC) ? cnt_q + CNT_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_ok;
  assign unused_ok = fpu_done | (FPU_TIMEOUT > CNT_W);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    pc_write        = 1'b0;
    ir_write        = 1'b0;
    adr_src         = 1'b0;
    mem_write       = 1'b0;
    reg_write       = 1'b0;
    float_reg_write = 1'b0;
    result_src      = RES_ALUOUT;
    alu_src_a       = SRCA_PC;
    alu_src_b       = SRCB_RS2;
    imm_src         = IMM_I;
    alu_control     = ALU_ADD;
    fpu_start       = 1'b0;
    illegal         = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEM_ADR;
`ifdef RV32F_FPU_EN
          OP_FLW, OP_FSW:    state_d = MEM_ADR;
          OP_FP:             state_d = FPU_EXEC;
`endif
          OP_RTYPE:          state_d = EXEC_R;
          OP_ITYPE:          state_d = EXEC_I;
          OP_JAL:            state_d = JAL;
          OP_BRANCH:         state_d = BEQ;
          default:           state_d = TRAP;
        endcase
      end
      // op[5] separates stores from loads in both integer and FP memory opcodes.
      MEM_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = op[5] ? IMM_S : IMM_I;
        state_d   = op[5] ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        adr_src = 1'b1;
        state_d = MEM_WB;
      end
      MEM_WB: begin
        result_src = RES_DATA;
        reg_write  = (op == OP_LOAD);
`ifdef RV32F_FPU_EN
        float_reg_write = (op == OP_FLW);
`endif
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = FETCH;
      end
      EXEC_R, EXEC_I: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = (state_q == EXEC_R) ? SRCB_RS2 : SRCB_IMM;
        alu_control = dec_alu;
        state_d     = dec_bad ? TRAP : ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        imm_src   = IMM_J;
        pc_write  = 1'b1;
        state_d   = ALU_WB;
      end
      BEQ: begin
        alu_src_a   = SRCA_RS1;
        alu_control = ALU_SUB;
        pc_write    = zero;
        state_d     = FETCH;
      end
`ifdef RV32F_FPU_EN
      FPU_EXEC: begin
        fpu_start = (cnt_q == '0);
        if (fpu_done)              state_d = FPU_WB;
        else if (cnt_q == CNT_LAST) state_d = TRAP;
      end
      FPU_WB: begin
        result_src      = RES_FPU;
        float_reg_write = 1'b1;
        state_d         = FETCH;
      end
`endif
      TRAP:    illegal = 1'b1;
      default: state_d = TRAP;
    endcase
    if (!rst_n) begin
      pc_write        = 1'b0;
      ir_write        = 1'b0;
      mem_write       = 1'b0;
      reg_write       = 1'b0;
      float_reg_write = 1'b0;
      fpu_start       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected cycle traces plus
// a table of end-to-end latencies, then randomized instruction streams.
module tb_multicycle_control_unit;

  localparam int TO = 16;
`ifdef RV32F_FPU_EN
  localparam bit FPU = 1'b1;
`else
  localparam bit FPU = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write, ir_write, adr_src, mem_write, reg_write, float_reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       fpu_start, illegal;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         done_at;
    int         rst_at;
    int         exp_ev;
    logic       exp_ill;
  } vec_t;

  logic clk, rst_n, funct7, zero, fpu_done;
  logic [6:0] op;
  logic [2:0] funct3;
  logic pc_write, ir_write, adr_src, mem_write, reg_write, float_reg_write, fpu_start, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  outs_t act;
  outs_t tr[$];
  vec_t  tbl[$];
  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control_unit #(.FPU_TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .fpu_done(fpu_done), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_write(mem_write), .reg_write(reg_write),
    .float_reg_write(float_reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .fpu_start(fpu_start), .illegal(illegal)
  );

  assign act = {pc_write, ir_write, adr_src, mem_write, reg_write, float_reg_write,
                result_src, alu_src_a, alu_src_b, imm_src, alu_control, fpu_start, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // RV32 ALU operation implied by funct3/funct7; returns 0 for unsupported funct3.
  function automatic bit alu_ref(input logic [2:0] f3, input logic sub_ok, output logic [2:0] ctl);
    ctl = 3'b000;
    if (f3 == 3'b000) begin ctl = sub_ok ? 3'b001 : 3'b000; return 1'b1; end
    if (f3 == 3'b010) begin ctl = 3'b101; return 1'b1; end
    if (f3 == 3'b110) begin ctl = 3'b011; return 1'b1; end
    if (f3 == 3'b111) begin ctl = 3'b010; return 1'b1; end
    return 1'b0;
  endfunction

  // Expected outputs, cycle by cycle, from FETCH until the next FETCH (or into TRAP).
  task automatic build_trace(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int done_at);
    outs_t e;
    bit is_ld, is_st, trap, ok;
    int n;
    tr.delete();
    trap = 1'b0;
    e = '0; e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
    tr.push_back(e);
    e = '0; e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; e.imm_src = 2'b10;
    tr.push_back(e);
    is_ld = (o == 7'b0000011) || (FPU && o == 7'b0000111);
    is_st = (o == 7'b0100011) || (FPU && o == 7'b0100111);
    if (is_ld || is_st) begin
      e = '0; e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.imm_src = is_st ? 2'b01 : 2'b00;
      tr.push_back(e);
      e = '0; e.adr_src = 1; e.mem_write = is_st;
      tr.push_back(e);
      if (is_ld) begin
        e = '0; e.result_src = 2'b01;
        e.reg_write = (o == 7'b0000011); e.float_reg_write = (o == 7'b0000111);
        tr.push_back(e);
      end
    end else if (o == 7'b0110011 || o == 7'b0010011) begin
      e = '0; e.alu_src_a = 2'b10; e.alu_src_b = (o == 7'b0110011) ? 2'b00 : 2'b01;
      ok = alu_ref(f3, f7 && (o == 7'b0110011), e.alu_control);
      tr.push_back(e);
      if (ok) begin e = '0; e.reg_write = 1; tr.push_back(e); end
      else trap = 1'b1;
    end else if (o == 7'b1101111) begin
      e = '0; e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1; e.imm_src = 2'b11;
      tr.push_back(e);
      e = '0; e.reg_write = 1; tr.push_back(e);
    end else if (o == 7'b1100011) begin
      e = '0; e.alu_src_a = 2'b10; e.alu_control = 3'b001; e.pc_write = z;
      tr.push_back(e);
    end else if (FPU && o == 7'b1010011) begin
      n = (done_at >= 0 && done_at < TO) ? done_at + 1 : TO;
      for (int k = 0; k < n; k++) begin
        e = '0; e.fpu_start = (k == 0); tr.push_back(e);
      end
      if (n == done_at + 1) begin
        e = '0; e.result_src = 2'b11; e.float_reg_write = 1; tr.push_back(e);
      end else trap = 1'b1;
    end else trap = 1'b1;
    if (trap) begin
      e = '0; e.illegal = 1;
      tr.push_back(e); tr.push_back(e);
    end
  endtask

  task automatic check(input string nm, input int idx, input outs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d op=%b f3=%b got=%h required=%h", nm, idx, op, funct3, act, exp);
    end
  endtask

  task automatic check_en(input string nm);
    n_tests++;
    if ({pc_write, ir_write, mem_write, reg_write, float_reg_write, fpu_start} !== 6'b0) begin
      n_fail++;
      $display("FAIL %s enables got=%b required=000000", nm,
               {pc_write, ir_write, mem_write, reg_write, float_reg_write, fpu_start});
    end
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    @(negedge clk);
    check_en(nm);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Runs one instruction from FETCH; ev = first cycle after 0 showing FETCH or TRAP.
  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                     input int done_at, input int rst_at, output int ev, output logic ev_ill);
    bit fp;
    build_trace(o, f3, f7, z, done_at);
    fp = FPU && (o == 7'b1010011);
    op = o; funct3 = f3; funct7 = f7; zero = z;
    ev = -1; ev_ill = 1'b0;
    for (int i = 0; i < tr.size(); i++) begin
      fpu_done = (fp && i >= 2) ? (i == 2 + done_at) : 1'($urandom_range(0, 1));
      if (i == rst_at) begin
        do_reset("mid_reset");
        fpu_done = 1'b0;
        return;
      end
      @(negedge clk);
      check("trace", i, tr[i]);
      if (i > 0 && ev < 0 && (ir_write === 1'b1 || illegal === 1'b1)) begin
        ev = i; ev_ill = illegal;
      end
      @(posedge clk); #1;
    end
    fpu_done = 1'b0;
    if (ev < 0 && (ir_write === 1'b1 || illegal === 1'b1)) begin
      ev = tr.size(); ev_ill = illegal;
    end
    if (tr[tr.size()-1].illegal) do_reset("trap_reset");
  endtask

  initial begin
    int ev;
    logic ev_ill;
    logic [6:0] ops[11];
    rst_n = 1'b0; op = '0; funct3 = '0; funct7 = 1'b0; zero = 1'b0; fpu_done = 1'b0;

    tbl.push_back('{7'b0000011, 3'b010, 1'b0, 1'b0, -1, -1, 5, 1'b0});
    tbl.push_back('{7'b0100011, 3'b010, 1'b0, 1'b0, -1, -1, 4, 1'b0});
    tbl.push_back('{7'b0110011, 3'b000, 1'b0, 1'b0, -1, -1, 4, 1'b0});
    tbl.push_back('{7'b0110011, 3'b000, 1'b1, 1'b0, -1, -1, 4, 1'b0});
    tbl.push_back('{7'b0010011, 3'b000, 1'b1, 1'b0, -1, -1, 4, 1'b0});
    tbl.push_back('{7'b0010011, 3'b010, 1'b0, 1'b0, -1, -1, 4, 1'b0});
    tbl.push_back('{7'b0110011, 3'b110, 1'b0, 1'b0, -1, -1, 4, 1'b0});
    tbl.push_back('{7'b0010011, 3'b111, 1'b0, 1'b0, -1, -1, 4, 1'b0});
    tbl.push_back('{7'b0110011, 3'b001, 1'b0, 1'b0, -1, -1, 3, 1'b1});
    tbl.push_back('{7'b1101111, 3'b000, 1'b0, 1'b0, -1, -1, 4, 1'b0});
    tbl.push_back('{7'b1100011, 3'b000, 1'b0, 1'b1, -1, -1, 3, 1'b0});
    tbl.push_back('{7'b1100011, 3'b000, 1'b0, 1'b0, -1, -1, 3, 1'b0});
    tbl.push_back('{7'b1111111, 3'b000, 1'b0, 1'b0, -1, -1, 2, 1'b1});
    tbl.push_back('{7'b0000111, 3'b010, 1'b0, 1'b0, -1, -1, FPU ? 5 : 2, !FPU});
    tbl.push_back('{7'b0100111, 3'b010, 1'b0, 1'b0, -1, -1, FPU ? 4 : 2, !FPU});
    tbl.push_back('{7'b1010011, 3'b000, 1'b0, 1'b0,  2, -1, FPU ? 6 : 2, !FPU});
    tbl.push_back('{7'b1010011, 3'b000, 1'b0, 1'b0, -1, -1, FPU ? 18 : 2, 1'b1});
    tbl.push_back('{7'b1010011, 3'b000, 1'b0, 1'b0, 15, -1, FPU ? 19 : 2, !FPU});
    tbl.push_back('{7'b1010011, 3'b000, 1'b0, 1'b0, -1,  3, -1, 1'b0});
    tbl.push_back('{7'b0100011, 3'b010, 1'b0, 1'b0, -1,  3, -1, 1'b0});
    tbl.push_back('{7'b0000011, 3'b010, 1'b0, 1'b0, -1, -1, 5, 1'b0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_en("reset_hold");
    n_tests++;
    if (illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_illegal got=%b required=0", illegal);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      run(tbl[k].op, tbl[k].f3, tbl[k].f7, tbl[k].z, tbl[k].done_at, tbl[k].rst_at, ev, ev_ill);
      if (tbl[k].rst_at < 0) begin
        n_tests++;
        if (ev != tbl[k].exp_ev || ev_ill !== tbl[k].exp_ill) begin
          n_fail++;
          $display("FAIL vec%0d op=%b latency got=%0d/ill=%b required=%0d/ill=%b",
                   k, tbl[k].op, ev, ev_ill, tbl[k].exp_ev, tbl[k].exp_ill);
        end
      end
    end

    ops = '{7'b0000011, 7'b0100011, 7'b0000111, 7'b0100111, 7'b0110011, 7'b0010011,
            7'b1101111, 7'b1100011, 7'b1010011, 7'b1010011, 7'b0};
    for (int r = 0; r < 80; r++) begin
      int pick, d, rs;
      logic [6:0] o;
      pick = $urandom_range(0, 10);
      o = (pick == 10) ? 7'($urandom) : ops[pick];
      d = $urandom_range(0, 19);
      if (d > 16) d = -1;
      rs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : -1;
      run(o, 3'($urandom), 1'($urandom), 1'($urandom), d, rs, ev, ev_ill);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter FPU_TIMEOUT, default 16: maximum cycles spent in FPU_EXEC waiting for fpu_done.
REQ-002 Parameter CNT_W, default 5: width of the FPU wait counter; 2^CNT_W SHALL exceed FPU_TIMEOUT.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 op  in  7  opcode from the instruction register.
REQ-006 funct3  in  3  instruction bits 14:12.
REQ-007 funct7  in  1  instruction bit 30.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 fpu_done  in  1  FPU result-valid pulse.
REQ-010 pc_write, ir_write, adr_src, mem_write, reg_write, float_reg_write  out  1 each  datapath enables and selects.
REQ-011 result_src, alu_src_a, alu_src_b, imm_src  out  2 each  datapath selects.
REQ-012 alu_control  out  3  ALU operation.
REQ-013 fpu_start  out  1  one-cycle FPU launch pulse.
REQ-014 illegal  out  1  sticky trap flag.

Function
REQ-015 FSM states: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, JAL, BEQ, FPU_EXEC, FPU_WB, TRAP.
REQ-016 FETCH: ir_write=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_control=add, result_src=10, pc_write=1; next DECODE.
REQ-017 DECODE: alu_src_a=01, alu_src_b=01, add (branch target); next by op: 0000011/0100011/0000111/0100111 -> MEM_ADR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1101111 -> JAL, 1100011 -> BEQ, 1010011 -> FPU_EXEC, any other -> TRAP.
REQ-018 MEM_ADR: alu_src_a=10, alu_src_b=01, add; loads -> MEM_READ, stores -> MEM_WRITE.
REQ-019 MEM_READ: adr_src=1, result_src=00 -> MEM_WB; MEM_WB: result_src=01, reg_write=1 for 0000011, float_reg_write=1 for 0000111 -> FETCH.
REQ-020 MEM_WRITE: adr_src=1, result_src=00, mem_write=1 -> FETCH.
REQ-021 EXEC_R/EXEC_I: alu_src_a=10, alu_src_b=00 (R) or 01 (I), alu_control decoded -> ALU_WB; ALU_WB: result_src=00, reg_write=1 -> FETCH.
REQ-022 ALU decode: funct3 000 -> add, except sub when EXEC_R and funct7=1; 010 slt=101; 110 or=011; 111 and=010; other funct3 -> TRAP instead of ALU_WB.
REQ-023 JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1 -> ALU_WB.
REQ-024 BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero -> FETCH.
REQ-025 FPU_EXEC: fpu_start=1 only in first cycle of the state; counter clears on entry, increments each cycle; fpu_done -> FPU_WB; counter reaching FPU_TIMEOUT without fpu_done -> TRAP; fpu_done on the timeout cycle wins.
REQ-026 FPU_WB: result_src=11, float_reg_write=1 -> FETCH.
REQ-027 TRAP: illegal=1, all enables 0; stays in TRAP until reset.
REQ-028 Imm_src: 00 I-type (loads, flw, EXEC_I), 01 S-type (stores), 10 B-type, 11 J-type; unspecified states drive 00.
REQ-029 All outputs are Moore (state-decoded) except pc_write in BEQ and alu_control in EXEC_R/EXEC_I; unlisted outputs are 0 in every state.

Reset
REQ-030 rst_n=0 at a clock edge: state=FETCH, counter=0, illegal=0; mid-FPU reset abandons the operation with no fpu_start or write.
REQ-031 While rst_n=0 all enables and fpu_start are 0.

Configuration
REQ-032 Macro RV32F_FPU_EN defined: opcodes 0000111, 0100111, 1010011 decoded per REQ-017.
REQ-033 Macro absent: those opcodes go to TRAP; FPU_EXEC/FPU_WB and counter not built; fpu_start and float_reg_write tied 0.

Structure
REQ-034 Shared package holds the state enum, opcode constants, ALU control constants and result_src encodings.
REQ-035 One sub-module, alu_decoder (combinational funct3/funct7 -> alu_control, illegal-funct flag); FSM in the top.

Verification
REQ-036 lw (op=0000011): FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, FETCH over 5 cycles; reg_write=1 only in MEM_WB.
REQ-037 beq with zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; 3 cycles each.
REQ-038 OP-FP, fpu_done after 3 cycles -> fpu_start single pulse, FPU_WB with float_reg_write=1, result_src=11.
REQ-039 OP-FP, fpu_done never -> TRAP after 16 cycles, illegal=1 held; rst_n=0 clears to FETCH.
REQ-040 op=1111111 -> TRAP from DECODE; without RV32F_FPU_EN op=1010011 -> TRAP.
REQ-041 rst_n=0 during MEM_WRITE cycle -> mem_write=0, next state FETCH.
